// File: rtl/chunked_add_seq_if.sv
// rtl/chunked_add_seq_if.sv - request/result bundle for the chunked sequential adder
interface chunked_add_seq_if #(
    parameter int N = 34
);
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         cout;

    modport master (
        output start, x, y, cin,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, x, y, cin,
        output busy, done, s, cout
    );
endinterface

// File: rtl/chunked_add_seq.sv
// rtl/chunked_add_seq.sv - N-bit adder computed one CHUNK-wide slice per clock
module chunked_add_seq #(
    parameter int N     = 34,
    parameter int CHUNK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    chunked_add_seq_if.slave  bus
);
    localparam int NCH    = (N + CHUNK - 1) / CHUNK;
    localparam int W      = NCH * CHUNK;
    localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LAST_W = N - (NCH - 1) * CHUNK;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            c_q, c_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [N-1:0]    s_q, s_d;
    logic            cout_q, cout_d;
    logic [CHUNK:0]  slice_sum;
    int              shift;
    logic [N-1:0]    slice_mask;
    logic [N-1:0]    slice_bits;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        c_d        = c_q;
        x_d        = x_q;
        y_d        = y_q;
        s_d        = s_q;
        cout_d     = cout_q;
        shift      = int'(idx_q) * CHUNK;
        slice_sum  = {1'b0, CHUNK'(x_q >> shift)} + {1'b0, CHUNK'(y_q >> shift)}
                   + (CHUNK+1)'(c_q);
        // Operands are zero-padded to W bits; truncating to N drops slice bits above N-1.
        slice_mask = N'({{(W-CHUNK){1'b0}}, {CHUNK{1'b1}}} << shift);
        slice_bits = N'({{(W-CHUNK){1'b0}}, slice_sum[CHUNK-1:0]} << shift);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = W'(bus.x);
                    y_d     = W'(bus.y);
                    c_d     = bus.cin;
                    idx_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                s_d = (s_q & ~slice_mask) | slice_bits;
                c_d = slice_sum[CHUNK];
                if (idx_q == IW'(NCH - 1)) begin
                    // In the last slice the carry into bit N sits just above the live bits.
                    cout_d  = slice_sum[LAST_W];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == ADD);
    assign bus.done = (state_q == DONE);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
endmodule

// File: doc/chunked_add_seq.md
CHUNKED_ADD_SEQ -- requirements
Module: chunked_add_seq

Interface
REQ-001 Parameter N, default 34: operand and sum width in bits; legal range N >= 1.
REQ-002 Parameter CHUNK, default 16: width of the adder slice used per cycle; legal range 1 <= CHUNK <= N.
REQ-003 Derived constant NCH = ceil(N/CHUNK): number of slices per operation (3 at defaults).
REQ-004 clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  request pulse; sampled only in IDLE.
REQ-007 x  input  N  operand A; captured on the accepting edge.
REQ-008 y  input  N  operand B; captured on the accepting edge.
REQ-009 cin  input  1  carry-in; captured on the accepting edge.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse; s and cout are valid in this cycle.
REQ-012 s  output  N  registered sum.
REQ-013 cout  output  1  registered carry out of bit N-1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL:
- capture x, y and cin;
- clear the slice index to 0 and clear s;
- enter ADD.
REQ-016 In ADD, each edge SHALL add the slice of x, the slice of y and the carry register, covering bits [i*CHUNK +: CHUNK].
- The slice sum SHALL be written into the same bits of s.
- The slice carry-out SHALL be stored in the carry register.
- The slice index SHALL increment.
REQ-017 The final slice SHALL zero-pad the operand bits above N-1.
- Only bits up to N-1 SHALL be written to s.
- The carry into bit N (the padded bit) SHALL become cout; bits above it SHALL be discarded.
REQ-018 On the edge that writes slice NCH-1, the FSM SHALL go ADD->DONE; on the next edge it SHALL go DONE->IDLE.
REQ-019 Timing, with the accepting edge numbered 0:
- slices are written on edges 1..NCH;
- busy is high from edge 0 until edge NCH;
- done is high from edge NCH until edge NCH+1.
REQ-020 Result: {cout, s} SHALL equal x + y + cin, computed exactly over N+1 bits.
REQ-021 After done, s and cout SHALL hold their values until the next accepted start.
REQ-022 start in ADD or DONE SHALL be ignored: no capture, no restart, no queueing.
- Any change on x, y or cin after the accepting edge SHALL NOT affect the result.
REQ-023 An accepting start in the cycle immediately after DONE (IDLE) SHALL begin a new operation with no extra bubble.
REQ-024 When NCH=1, busy and done SHALL behave per REQ-019 with NCH=1, giving a total latency of 1 edge.
REQ-025 busy and done SHALL NOT be high in the same cycle.

Reset
REQ-026 While rst_n=0, outputs SHALL be forced asynchronously to: busy=0, done=0, s=0, cout=0.
REQ-027 While rst_n=0, internal state SHALL be forced asynchronously to: state=IDLE, slice index=0, carry register=0, captured operands=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow.
REQ-029 After rst_n rises, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-030 Carry across all slices (N=34, CHUNK=16):
- stimulus: x=34'h3_FFFF_FFFF, y=1, cin=0, start pulse;
- response: done high 3 edges after acceptance, s=0, cout=1, busy high for exactly 3 cycles.
REQ-031 Carry-in only (N=34): x=34'h0_0000_FFFF, y=0, cin=1 -> s=34'h0_0001_0000, cout=0.
REQ-032 Start while busy: a second start at edge 1 with different operands SHALL be ignored; the result SHALL equal the first operation's sum and exactly one done pulse SHALL occur.
REQ-033 Reset mid-operation: rst_n=0 between edges 1 and 2 -> outputs 0 immediately, no done pulse.
- Then start with x=5, y=7, cin=0 -> s=12, cout=0.
REQ-034 Back-to-back operations: a start in the cycle after done SHALL be accepted with no bubble.
- A randomized run of 1000 operations SHALL match {cout, s} = x + y + cin.
REQ-035 Single-slice configuration (N=16, CHUNK=16): x=16'hFFFF, y=16'hFFFF, cin=1 -> s=16'hFFFF, cout=1, done at edge 1.
